// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: architectural widths, instr[31:21] opcode patterns,
// fetch FSM state encoding and the branch target helper.
package legv8_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // Opcodes narrower than 11 bits are left-aligned in instr[31:21] with trailing zeros.
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_HALT = 11'b11111111111;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HALT = 2'd3
    } fetch_state_e;

    // Word offset scaled to bytes; wraps modulo 2^64.
    function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc,
                                                      input logic [XLEN-1:0] off);
        return pc + (off << 2);
    endfunction

endpackage

// File: rtl/ifid_skid_buffer.sv
// One-entry holding register for a fetched word that IF/ID could not accept
// because decode was stalled. Flush wins over write, write wins over read.
module ifid_skid_buffer
    import legv8_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            wr_en_i,
    input  logic [ILEN-1:0] wr_instr_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic            rd_en_i,
    output logic            valid_o,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q;
    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (wr_en_i) begin
            valid_q <= 1'b1;
            instr_q <= wr_instr_i;
            pc_q    <= wr_pc_i;
        end else if (rd_en_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// LEGv8 IF stage: PC register, single-outstanding fetch FSM with branch redirect
// and response kill, and the IF/ID pipeline register backed by a one-entry skid.
module instruction_fetch_stage
    import legv8_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 64'h0,
    parameter logic [XLEN-1:0] PC_STEP     = 64'd4,
    parameter logic [10:0]     HALT_OPCODE = 11'b11111111111
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            id_stall,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_branch_pc,
    input  logic [XLEN-1:0] ex_branch_off,
    output logic            ifid_valid,
    output logic [ILEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic            halted
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [ILEN-1:0] ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;

    logic            skid_valid;
    logic [ILEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic            skid_wr;
    logic            skid_rd;

    logic            redirect_en;
    logic            req_fire;
    logic            deliver;
    logic            rsp_is_halt;

    assign redirect_en    = ex_redirect && (state_q != FETCH_HALT);
    assign imem_req_valid = (state_q == FETCH_REQ) && !skid_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign deliver        = (state_q == FETCH_WAIT) && imem_rsp_valid && !kill_q && !redirect_en;
    assign rsp_is_halt    = (imem_rsp_data[31:21] == HALT_OPCODE);
    assign halted         = (state_q == FETCH_HALT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        unique case (state_q)
            FETCH_IDLE: state_d = FETCH_REQ;
            FETCH_REQ: begin
                if (req_fire) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q) begin
                        state_d = FETCH_REQ;
                        kill_d  = 1'b0;
                    end else if (rsp_is_halt) begin
                        state_d = FETCH_HALT;
                    end else begin
                        state_d = FETCH_REQ;
                        pc_d    = pc_q + PC_STEP;
                    end
                end
            end
            FETCH_HALT: state_d = FETCH_HALT;
            default:    state_d = FETCH_IDLE;
        endcase

        // A redirect must not lose track of a request already in flight: it is
        // marked killed and the FSM waits for its response before refetching.
        if (redirect_en) begin
            pc_d = branch_target(ex_branch_pc, ex_branch_off);
            if (state_q == FETCH_WAIT && !imem_rsp_valid) begin
                state_d = FETCH_WAIT;
                kill_d  = 1'b1;
            end else if (state_q == FETCH_REQ && req_fire) begin
                state_d = FETCH_WAIT;
                kill_d  = 1'b1;
            end else begin
                state_d = FETCH_REQ;
                kill_d  = 1'b0;
            end
        end
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (redirect_en) begin
            ifid_valid_d = 1'b0;
        end else if (!id_stall) begin
            if (skid_valid) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = skid_instr;
                ifid_pc_d    = skid_pc;
            end else if (deliver) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = imem_rsp_data;
                ifid_pc_d    = pc_q;
            end else if (state_q != FETCH_HALT) begin
                // Once halted the HALT word stays visible instead of bubbling out.
                ifid_valid_d = 1'b0;
            end
        end
    end

    assign skid_wr = deliver && (id_stall || skid_valid);
    assign skid_rd = !id_stall && skid_valid;

    ifid_skid_buffer u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect_en),
        .wr_en_i    (skid_wr),
        .wr_instr_i (imem_rsp_data),
        .wr_pc_i    (pc_q),
        .rd_en_i    (skid_rd),
        .valid_o    (skid_valid),
        .instr_o    (skid_instr),
        .pc_o       (skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH_IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a behavioural instruction memory
// whose response latency is programmable per scenario.
module tb_instruction_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_stall;
    logic        ex_redirect;
    logic [63:0] ex_branch_pc;
    logic [63:0] ex_branch_off;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [63:0] ifid_pc;
    logic        halted;

    int          n_chk = 0;
    int          n_pass = 0;
    int          rsp_delay = 1;
    logic [63:0] halt_addr = '1;

    instruction_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_stall       (id_stall),
        .ex_redirect    (ex_redirect),
        .ex_branch_pc   (ex_branch_pc),
        .ex_branch_off  (ex_branch_off),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == halt_addr) return 32'hFFE0_0000;
        return 32'h8B00_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30 && !ifid_valid; i++) tick();
        check(tag, ifid_valid, 1);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 30 && !imem_req_valid; i++) tick();
        check(tag, imem_req_valid, 1);
    endtask

    // Memory: acceptance is predicted on the falling edge before the rising edge
    // that takes it; the word is returned rsp_delay cycles after that edge.
    initial begin
        bit          acc;
        bit          pend;
        int          cnt;
        logic [63:0] acc_addr;
        logic [63:0] pend_addr;
        acc = 0; pend = 0; cnt = 0; acc_addr = '0; pend_addr = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (acc) begin
                pend      = 1;
                cnt       = rsp_delay;
                pend_addr = acc_addr;
            end
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr);
                    pend           = 0;
                end
            end
            acc      = imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
        end
    end

    initial begin
        int          nreq;
        int          nval;
        bit          got_req;
        logic [63:0] first_req;

        rst_n = 1'b0; imem_req_ready = 1'b1; id_stall = 1'b0;
        ex_redirect = 1'b0; ex_branch_pc = '0; ex_branch_off = '0;

        // 1: reset values, then sequential fetch 0,4,8
        tick(); tick();
        check("rst_ifid_valid", ifid_valid, 0);
        check("rst_ifid_instr", ifid_instr, 0);
        check("rst_ifid_pc", ifid_pc, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_halted", halted, 0);
        rst_n = 1'b1;
        tick();
        check("t1_req_valid", imem_req_valid, 1);
        check("t1_req_addr", imem_req_addr, 64'h0);
        check("t1_no_early_valid", ifid_valid, 0);
        tick();
        check("t1_no_early_valid2", ifid_valid, 0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            wait_valid("t1_word_valid");
            check("t1_word_pc", ifid_pc, 64'(k * 4));
            check("t1_word_instr", ifid_instr, 64'(32'h8B00_0000 + k * 4));
        end

        // 2: taken branch 0x10 + (-2 words) = 0x8, IF/ID flushed
        ex_redirect = 1'b1; ex_branch_pc = 64'h10; ex_branch_off = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        ex_redirect = 1'b0;
        check("t2_flush", ifid_valid, 0);
        wait_req("t2_req_seen");
        check("t2_req_addr", imem_req_addr, 64'h8);
        wait_valid("t2_word_valid");
        check("t2_word_pc", ifid_pc, 64'h8);
        check("t2_word_instr", ifid_instr, 64'h8B00_0008);

        // 3: redirect while waiting on a slow response
        rsp_delay = 3;
        tick();
        ex_redirect = 1'b1; ex_branch_pc = 64'h100; ex_branch_off = 64'h1;
        tick();
        ex_redirect = 1'b0;
        check("t3_flush", ifid_valid, 0);
        got_req = 0; first_req = '0;
        for (int i = 0; i < 30 && !ifid_valid; i++) begin
            tick();
            if (imem_req_valid && !got_req) begin
                got_req   = 1;
                first_req = imem_req_addr;
            end
        end
        check("t3_req_seen", got_req, 1);
        check("t3_req_addr", first_req, 64'h104);
        check("t3_word_valid", ifid_valid, 1);
        check("t3_word_pc", ifid_pc, 64'h104);

        // 4: decode stall while the next word returns
        rsp_delay = 1;
        id_stall = 1'b1;
        tick(); tick();
        check("t4_hold_pc", ifid_pc, 64'h104);
        check("t4_no_req", imem_req_valid, 0);
        tick(); tick();
        check("t4_hold_valid", ifid_valid, 1);
        check("t4_hold_pc2", ifid_pc, 64'h104);
        check("t4_no_req2", imem_req_valid, 0);
        id_stall = 1'b0;
        halt_addr = 64'h110;
        tick();
        check("t4_drain_valid", ifid_valid, 1);
        check("t4_drain_pc", ifid_pc, 64'h108);
        check("t4_drain_instr", ifid_instr, 64'h8B00_0108);
        check("t4_resume_req", imem_req_valid, 1);
        check("t4_resume_addr", imem_req_addr, 64'h10C);

        // 5: HALT word ends fetching
        for (int i = 0; i < 30 && !(ifid_valid && ifid_pc == 64'h110); i++) tick();
        check("t5_halt_pc", ifid_pc, 64'h110);
        check("t5_halt_instr", ifid_instr, 64'hFFE0_0000);
        check("t5_halted", halted, 1);
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_req_valid) nreq++;
        end
        check("t5_no_req", nreq, 0);
        check("t5_halt_kept", ifid_valid, 1);
        check("t5_halted_kept", halted, 1);

        // 6: reset in the middle of an outstanding fetch
        rst_n = 1'b0;
        #1;
        check("t6_halt_cleared", halted, 0);
        tick();
        rst_n = 1'b1; halt_addr = '1;
        wait_valid("t6_first_valid");
        check("t6_first_pc", ifid_pc, 64'h0);
        id_stall = 1'b1; rsp_delay = 4;
        tick();
        check("t6_pre_valid", ifid_valid, 1);
        rst_n = 1'b0; imem_req_ready = 1'b0; id_stall = 1'b0;
        #1;
        check("t6_async_valid", ifid_valid, 0);
        check("t6_async_instr", ifid_instr, 0);
        check("t6_async_pc", ifid_pc, 0);
        check("t6_async_req", imem_req_valid, 0);
        tick(); tick();
        rst_n = 1'b1;
        nval = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ifid_valid) nval++;
        end
        check("t6_stale_ignored", nval, 0);
        check("t6_req_valid", imem_req_valid, 1);
        check("t6_req_addr", imem_req_addr, 64'h0);
        rsp_delay = 1; imem_req_ready = 1'b1;
        wait_valid("t6_refetch_valid");
        check("t6_refetch_pc", ifid_pc, 64'h0);
        check("t6_refetch_instr", ifid_instr, 64'h8B00_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
